// File: rtl/alu_operand_stage_if.sv
// Decode-side and execute-side signal bundle for the ALU operand stage.
// The slave modport is the stage's view; the master modport is the
// surrounding pipeline (decode, forwarding sources, execute adder).
interface alu_operand_stage_if #(
  parameter int WIDTH = 16,
  parameter int RA    = 3
);
  // Decode-side handshake and decoded fields
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [RA-1:0]    rs1_addr;
  logic [RA-1:0]    rs2_addr;
  logic [WIDTH-1:0] rs1_data;
  logic [WIDTH-1:0] rs2_data;
  logic [WIDTH-1:0] imm;
  logic             use_imm;
  logic [RA-1:0]    rd_addr;

  // Forwarding sources
  logic             fx_we;
  logic [RA-1:0]    fx_rd;
  logic [WIDTH-1:0] fx_data;
  logic             fw_we;
  logic [RA-1:0]    fw_rd;
  logic [WIDTH-1:0] fw_data;

  // Carry-flag update from the adder and branch-recovery flush
  logic             c_we;
  logic             c_in;
  logic             flush;

  // Execute-side handshake and adder operands
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [RA-1:0]    out_rd;
  logic             cflag;

  modport slave (
    input  in_valid, op, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, use_imm,
           rd_addr, fx_we, fx_rd, fx_data, fw_we, fw_rd, fw_data, c_we, c_in,
           flush, out_ready,
    output in_ready, out_valid, op_a, op_b, op_cin, out_rd, cflag
  );

  modport master (
    output in_valid, op, rs1_addr, rs2_addr, rs1_data, rs2_data, imm, use_imm,
           rd_addr, fx_we, fx_rd, fx_data, fw_we, fw_rd, fw_data, c_we, c_in,
           flush, out_ready,
    input  in_ready, out_valid, op_a, op_b, op_cin, out_rd, cflag
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures decoded operands with hazard forwarding,
// folds SUB/ADC/SBB into a plain add (B inversion + carry-in select) and
// holds the architectural carry flag fed back from the execute adder.
module alu_operand_stage #(
  parameter int WIDTH = 16,
  parameter int RA    = 3
) (
  input logic                clk,
  input logic                rst,
  alu_operand_stage_if.slave bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic [RA-1:0]    out_rd_q, out_rd_d;
  logic             cflag_q, cflag_d;

  logic             in_ready;
  logic             accept;
  logic             c_eff;
  logic [WIDTH-1:0] rs1_res;
  logic [WIDTH-1:0] rs2_res;
  logic [WIDTH-1:0] b_sel;

  // r0 is hard-wired to zero and never forwarded; EX/MEM is the younger
  // result, so it takes priority over MEM/WB.
  function automatic logic [WIDTH-1:0] fwd_operand(
    input logic [RA-1:0]    addr,
    input logic [WIDTH-1:0] rf_data,
    input logic             fx_we,
    input logic [RA-1:0]    fx_rd,
    input logic [WIDTH-1:0] fx_data,
    input logic             fw_we,
    input logic [RA-1:0]    fw_rd,
    input logic [WIDTH-1:0] fw_data
  );
    logic [WIDTH-1:0] r;
    if (addr == '0)                        r = '0;
    else if (fx_we && (fx_rd == addr))     r = fx_data;
    else if (fw_we && (fw_rd == addr))     r = fw_data;
    else                                   r = rf_data;
    return r;
  endfunction

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  // Same-cycle carry bypass so an ADC/SBB behind a flag-setting op sees it
  assign c_eff    = bus.c_we ? bus.c_in : cflag_q;

  assign rs1_res = fwd_operand(bus.rs1_addr, bus.rs1_data, bus.fx_we, bus.fx_rd,
                               bus.fx_data, bus.fw_we, bus.fw_rd, bus.fw_data);
  assign rs2_res = fwd_operand(bus.rs2_addr, bus.rs2_data, bus.fx_we, bus.fx_rd,
                               bus.fx_data, bus.fw_we, bus.fw_rd, bus.fw_data);
  assign b_sel   = bus.use_imm ? bus.imm : rs2_res;

  // Next-state: flush beats accept; accept beats drain; data only moves on accept
  always_comb begin
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_cin_d    = op_cin_q;
    out_rd_d    = out_rd_q;
    cflag_d     = c_eff;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op_a_d      = rs1_res;
      out_rd_d    = bus.rd_addr;
      case (op_e'(bus.op))
        OP_ADD: begin op_b_d = b_sel;  op_cin_d = 1'b0;  end
        OP_SUB: begin op_b_d = ~b_sel; op_cin_d = 1'b1;  end
        OP_ADC: begin op_b_d = b_sel;  op_cin_d = c_eff; end
        default: begin op_b_d = ~b_sel; op_cin_d = c_eff; end
      endcase
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Stage register and carry flag; reset clears everything asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_cin_q    <= 1'b0;
      out_rd_q    <= '0;
      cflag_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_cin_q    <= op_cin_d;
      out_rd_q    <= out_rd_d;
      cflag_q     <= cflag_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_cin    = op_cin_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.cflag     = cflag_q;

endmodule
